// File: rtl/spi_slave.sv
// SPI slave, LSB first: one IDLE setup edge, DATA_WIDTH shift edges, one DONE edge per frame.
// A single-entry transmit buffer feeds tx_shift at each frame start.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  MOSI_in,
  output logic                  MISO_out,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic [3:0]            bit_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] LAST = 4'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  miso_q, miso_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      buf_full_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      buf_full_q  <= buf_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_buf_d    = tx_buf_q;
    buf_full_d  = buf_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    bit_cnt_d   = bit_cnt_q;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!CS) begin
          state_d    = SHIFT;
          tx_shift_d = buf_full_q ? tx_buf_q : '0;
          buf_full_d = 1'b0;
        end
      end
      SHIFT: begin
        if (CS) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
        end else begin
          rx_shift_d = {MOSI_in, rx_shift_q[DATA_WIDTH-1:1]};
          tx_shift_d = tx_shift_q >> 1;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // Load is judged on the buffer state before this edge, so a load that
    // coincides with a start only lands when the buffer was already empty.
    if (tx_load && !buf_full_q) begin
      tx_buf_d   = tx_data;
      buf_full_d = 1'b1;
    end

    miso_d = (state_d == SHIFT) ? tx_shift_d[0] : 1'b0;
  end

  assign MISO_out  = miso_q;
  assign tx_ready  = ~buf_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign bit_count = bit_cnt_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame length in bits; the bit counter width SHALL be 4 bits, which covers all legal values.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port CS  input  1  chip select, active low.
REQ-005 SHALL have port MOSI_in  input  1  serial data from master, LSB first.
REQ-006 SHALL have port MISO_out  output  1  serial data to master, LSB first.
REQ-007 SHALL have port tx_data  input  DATA_WIDTH  word to return on the next frame.
REQ-008 SHALL have port tx_load  input  1  writes tx_data into the transmit buffer.
REQ-009 SHALL have port tx_ready  output  1  high while the transmit buffer is empty.
REQ-010 SHALL have port rx_data  output  DATA_WIDTH  last complete received word.
REQ-011 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on an aborted frame.
REQ-013 SHALL have port bit_count  output  4  number of bits received in the current frame.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-015 IDLE: on an edge with CS=0 SHALL go to SHIFT with bit_count=0, moving the transmit buffer into tx_shift and emptying the buffer; no bit is sampled on this edge.
REQ-016 IDLE start with an empty buffer SHALL load tx_shift with all zeros.
REQ-017 SHIFT: each edge with CS=0 SHALL do rx_shift <= {MOSI_in, rx_shift[DATA_WIDTH-1:1]}, tx_shift >>= 1, and bit_count += 1.
REQ-018 On the edge sampling bit DATA_WIDTH-1, SHALL load rx_data with the completed word, raise rx_valid for exactly the following cycle, and enter DONE.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE; bit_count SHALL hold DATA_WIDTH in DONE and return to 0 in IDLE.
REQ-020 Back-to-back frames: if CS is still 0 in IDLE, SHALL start a new frame on that edge per REQ-015, giving a minimum frame period of DATA_WIDTH+2 cycles.
REQ-021 MISO_out SHALL equal tx_shift[0] in SHIFT and 0 in IDLE and DONE; it is a registered value with no tristate.
REQ-022 CS=1 sampled in SHIFT SHALL abort: go to IDLE, pulse frame_err for one cycle, set bit_count to 0, leave rx_data unchanged, and raise no rx_valid.
REQ-023 CS=1 in DONE SHALL have no effect; the frame is already complete.
REQ-024 tx_load with tx_ready=1 SHALL capture tx_data, and tx_ready SHALL go low on the next cycle.
REQ-025 tx_load with tx_ready=0 SHALL be ignored, leaving the buffer unchanged.
REQ-026 tx_load on the same edge as a frame start with an empty buffer SHALL fill the buffer for the next frame; the current frame sends zeros.
REQ-027 tx_ready SHALL rise on the cycle after a frame start empties a full buffer.
REQ-028 A new rx_valid SHALL overwrite rx_data without requiring an acknowledge.

Reset
REQ-029 On reset assertion, regardless of clk, SHALL immediately set state=IDLE, MISO_out=0, tx_ready=1, rx_data=0, rx_valid=0, frame_err=0, bit_count=0, and clear both shift registers and the buffer.
REQ-030 Reset mid-frame SHALL discard the partial frame with no rx_valid and no frame_err; operation SHALL resume at the first clk edge after deassertion.

Verification
REQ-031 Drive CS=0 for 10 cycles with MOSI bits LSB first of 0xA5 -> rx_data=0xA5, rx_valid high for 1 cycle at cycle 10, bit_count steps 0..8.
REQ-032 tx_load 0x3C while idle, then run a frame -> MISO_out emits 0,0,1,1,1,1,0,0 and tx_ready returns to 1 one cycle after the start.
REQ-033 Raise CS after 4 bits -> frame_err pulses once, rx_data keeps its old value, no rx_valid, and the next full frame with 0x5A captures 0x5A.
REQ-034 Hold CS low for 20 cycles with 0x0F then 0xF0 -> two rx_valid pulses 10 cycles apart carrying 0x0F then 0xF0; MISO_out sends 0x00 for a frame with an empty buffer.
REQ-035 Assert reset mid-frame after 3 bits -> all outputs take reset values asynchronously, then a subsequent 0xC3 frame is received correctly.
REQ-036 tx_load 0x11 then tx_load 0x22 before any frame -> the frame sends 0x11, and 0x22 is ignored.
